adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Parametrised scanning controller for a multiplexed successive-approximation ADC (ADC0808/0809 style): channel select, ALE, START, EOC, OE. Replaces free-running, multi-clock-domain ADC glue with one synchronous FSM in the `clk` domain. Adds:
- a per-channel enable mask
- single-scan and continuous modes
- an EOC timeout
- per-sample strobes

It sits between the Wishbone control register block and the external converter pins.

## Interface
- `N_CH`, 8: number of analog channels, 2..16.
- `SEL_W`, 3: width of `adc_sel`; equals ceil(log2(`N_CH`)).
- `DATA_W`, 8: converter data width.
- `CLK_DIV`, 79: `adc_clk` half-period in `clk` cycles (≥1).
- `SETTLE`, 4: `clk` cycles ALE/select held before START (≥1).
- `START_W`, 4: START pulse width in `clk` cycles (≥1).
- `OE_W`, 3: OE assertion length in `clk` cycles; data captured on the last cycle (≥2).
- `TIMEOUT`, 20000: max `clk` cycles from START falling to EOC rising.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request.
- `single`  in  1  1 = stop after one full scan; 0 = continuous.
- `ch_mask`  in  `N_CH`  channel enable mask; bit i enables channel i.
- `err_clr`  in  1  single-cycle pulse; clears `err_timeout`.
- `adc_eoc`  in  1  end of conversion, asynchronous to `clk`.
- `adc_data`  in  `DATA_W`  converter output bus.
- `adc_clk`  out  1  divided converter clock.
- `adc_ale`  out  1  address latch enable.
- `adc_start`  out  1  conversion start.
- `adc_oe`  out  1  output enable.
- `adc_sel`  out  `SEL_W`  mux address.
- `ch_data`  out  `N_CH*DATA_W`  channel i in bits [i*`DATA_W` +: `DATA_W`].
- `sample_stb`  out  1  one-cycle pulse when a channel register updates.
- `sample_ch`  out  `SEL_W`  channel index qualified by `sample_stb`.
- `scan_done`  out  1  one-cycle pulse after the last enabled channel of a scan.
- `busy`  out  1  FSM not in IDLE.
- `err_timeout`  out  1  sticky EOC-timeout flag.

## Operation
- Reset value of every output and register is 0: `ch_data` = 0, FSM = IDLE, `adc_sel` = 0, `adc_clk` = 0.
- `adc_clk`: free-running divider. Toggles after every `CLK_DIV` `clk` cycles, independent of the FSM.
- `adc_eoc` passes through a 2-flop synchroniser before the FSM uses it.

FSM states:
- **IDLE**:
  - Entered on reset, after a single scan completes, or when `enable` is low at NEXT.
  - Stays here while `ch_mask` = 0.
  - When `enable`=1 and `ch_mask`≠0, latches the lowest set mask bit into `adc_sel`, then goes to SELECT.
- **SELECT**: `adc_ale`=1 for `SETTLE` cycles, then START.
- **START**: `adc_start`=1 for `START_W` cycles; the timeout counter clears. Then WAIT_LO.
- **WAIT_LO**: waits for synchronised EOC = 0 (conversion begun), then WAIT_HI.
- **WAIT_HI**: waits for synchronised EOC = 1, then READ.
- **WAIT_LO/WAIT_HI timeout**:
  - The timeout counter runs in both states.
  - When it reaches `TIMEOUT`, set `err_timeout`, skip the capture and go to NEXT.
- **READ**:
  - `adc_oe`=1 for `OE_W` cycles.
  - On the last cycle, the selected channel's `ch_data` slice ← `adc_data`, and `sample_stb`=1 with `sample_ch`=`adc_sel`.
  - Then NEXT.
- **NEXT** (one cycle): finds the next set bit of `ch_mask` (sampled here) with an index strictly greater than `adc_sel`.
  - Found: `adc_sel` ← that index; go to SELECT if `enable`=1, else IDLE.
  - None found: pulse `scan_done` and wrap to the lowest set bit. Go to IDLE if `single`=1, `enable`=0 or `ch_mask`=0; otherwise go to SELECT.

Rules:
- `enable` falling mid-conversion does not abort; the current channel completes.
- `adc_sel` changes only in IDLE or NEXT.
- `err_clr` and a timeout in the same cycle: set wins.
- Asserting `reset` mid-operation returns every output to 0 immediately, including ALE/START/OE.

## Timing
- Per-channel latency, with EOC falling E cycles after START ends and rising C cycles later:
  1 (IDLE/NEXT) + `SETTLE` + `START_W` + (E + 2) + (C + 2) + `OE_W` `clk` cycles.
- The +2 terms are synchroniser delay.
- `sample_stb` is coincident with the last OE cycle; `ch_data` is valid from the next cycle onward.
- `scan_done` is asserted in the NEXT cycle that follows the final channel's READ or timeout.

## Test plan
- **Full scan**: `ch_mask`=8'hFF, `single`=1; model returns data 8'h10+i for channel i.
  - Required: eight `sample_stb` pulses with `sample_ch` 0..7 in order, `ch_data` slices 10..17, one `scan_done`, then IDLE with `busy`=0.
- **Sparse mask**: `ch_mask`=8'b1010_0100, `enable`=1, `single`=0.
  - Required: `adc_sel` sequence 2,5,7,2,5,…; `scan_done` after each 7.
  - Channels 0,1,3,4,6 stay at reset value 0.
- **Timeout**: `TIMEOUT`=50; model never raises EOC on channel 3, `ch_mask`=8'h0F.
  - Required: `err_timeout`=1, no `sample_stb` for channel 3, `scan_done` still pulses.
  - `err_clr` then clears the flag.
- **Stop**: drop `enable` during WAIT_HI of channel 1.
  - Required: channel 1 is captured, then IDLE; no SELECT for channel 2.
- **Reset mid-READ**: pull `reset` low while `adc_oe`=1.
  - Required: all outputs 0 within the same cycle, `ch_data`=0; FSM restarts at the lowest enabled channel after release.
- **Clock divider**: `CLK_DIV`=79.
  - Required: `adc_clk` period 158 `clk` cycles at 50 % duty, first rising edge 79 cycles after reset release.

Source files
------------

// File: rtl/adc_scan_ctrl_if.sv
// Pin-level bundle between the scan controller and an ADC0808/0809-style converter.
interface adc_scan_ctrl_if #(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
);
  logic              adc_clk;
  logic              adc_ale;
  logic              adc_start;
  logic              adc_oe;
  logic [SEL_W-1:0]  adc_sel;
  logic              adc_eoc;
  logic [DATA_W-1:0] adc_data;

  modport master (
    output adc_clk, adc_ale, adc_start, adc_oe, adc_sel,
    input  adc_eoc, adc_data
  );

  modport slave (
    input  adc_clk, adc_ale, adc_start, adc_oe, adc_sel,
    output adc_eoc, adc_data
  );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Scanning controller for a multiplexed SAR ADC: walks the enabled channels,
// sequences ALE/START/EOC/OE and stores one result register per channel.
//
// state   | meaning
// IDLE    | waiting for enable with a non-zero channel mask
// SELECT  | ALE high, mux address settling
// START   | START pulse to the converter, timeout counter armed
// WAIT_LO | waiting for synchronised EOC low (conversion begun)
// WAIT_HI | waiting for synchronised EOC high (conversion done)
// READ    | OE high, data captured on the final cycle
// NEXT    | pick the next enabled channel or end the scan
module adc_scan_ctrl #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 79,
  parameter int SETTLE  = 4,
  parameter int START_W = 4,
  parameter int OE_W    = 3,
  parameter int TIMEOUT = 20000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   single,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic                   err_clr,
  adc_scan_ctrl_if.master        adc,
  output logic [N_CH*DATA_W-1:0] ch_data,
  output logic                   sample_stb,
  output logic [SEL_W-1:0]       sample_ch,
  output logic                   scan_done,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int PH_MAX = (SETTLE > START_W) ? ((SETTLE > OE_W) ? SETTLE : OE_W)
                                             : ((START_W > OE_W) ? START_W : OE_W);
  localparam int PH_W  = $clog2(PH_MAX + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, START, WAIT_LO, WAIT_HI, READ, NEXT
  } state_t;

  state_t           state;
  logic [PH_W-1:0]  ph_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [SEL_W-1:0] sel_q;
  logic             adc_clk_q, ale_q, start_q, oe_q;
  logic             eoc_meta, eoc_sync;
  logic [SEL_W-1:0] low_idx, nxt_idx;
  logic             nxt_found;

  assign adc.adc_clk   = adc_clk_q;
  assign adc.adc_ale   = ale_q;
  assign adc.adc_start = start_q;
  assign adc.adc_oe    = oe_q;
  assign adc.adc_sel   = sel_q;
  assign busy          = (state != IDLE);

  // Free-running converter clock, not gated by the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt   <= DIV_W'(CLK_DIV - 1);
      adc_clk_q <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt   <= DIV_W'(CLK_DIV - 1);
      adc_clk_q <= ~adc_clk_q;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eoc_meta <= 1'b0;
      eoc_sync <= 1'b0;
    end else begin
      eoc_meta <= adc.adc_eoc;
      eoc_sync <= eoc_meta;
    end
  end

  // Lowest enabled channel, and lowest enabled channel above the current one.
  always_comb begin
    low_idx   = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_idx = SEL_W'(i);
        if (i > int'(sel_q)) begin
          nxt_idx   = SEL_W'(i);
          nxt_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ph_cnt      <= '0;
      to_cnt      <= '0;
      sel_q       <= '0;
      ale_q       <= 1'b0;
      start_q     <= 1'b0;
      oe_q        <= 1'b0;
      ch_data     <= '0;
      sample_stb  <= 1'b0;
      sample_ch   <= '0;
      scan_done   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      scan_done  <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (err_clr) err_timeout <= 1'b0;

      unique case (state)
        IDLE: begin
          if (enable && (ch_mask != '0)) begin
            sel_q  <= low_idx;
            ale_q  <= 1'b1;
            ph_cnt <= PH_W'(SETTLE - 1);
            state  <= SELECT;
          end
        end
        SELECT: begin
          if (ph_cnt == '0) begin
            ale_q   <= 1'b0;
            start_q <= 1'b1;
            ph_cnt  <= PH_W'(START_W - 1);
            state   <= START;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        START: begin
          if (ph_cnt == '0) begin
            start_q <= 1'b0;
            to_cnt  <= TO_W'(TIMEOUT - 1);
            state   <= WAIT_LO;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        WAIT_LO: begin
          if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
          if (!eoc_sync) begin
            state <= WAIT_HI;
          end else if (to_cnt == '0) begin
            err_timeout <= 1'b1;
            scan_done   <= !nxt_found;
            state       <= NEXT;
          end
        end
        WAIT_HI: begin
          if (to_cnt != '0) to_cnt <= to_cnt - 1'b1;
          if (eoc_sync) begin
            oe_q   <= 1'b1;
            ph_cnt <= PH_W'(OE_W - 1);
            state  <= READ;
          end else if (to_cnt == '0) begin
            err_timeout <= 1'b1;
            scan_done   <= !nxt_found;
            state       <= NEXT;
          end
        end
        READ: begin
          // Strobe is registered one cycle early so it lines up with the last OE cycle.
          if (ph_cnt == PH_W'(1)) begin
            sample_stb <= 1'b1;
            sample_ch  <= sel_q;
          end
          if (ph_cnt == '0) begin
            oe_q <= 1'b0;
            ch_data[int'(sel_q)*DATA_W +: DATA_W] <= adc.adc_data;
            scan_done <= !nxt_found;
            state     <= NEXT;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        NEXT: begin
          if (nxt_found) begin
            sel_q <= nxt_idx;
            if (enable) begin
              ale_q  <= 1'b1;
              ph_cnt <= PH_W'(SETTLE - 1);
              state  <= SELECT;
            end else begin
              state <= IDLE;
            end
          end else begin
            sel_q <= low_idx;
            if (single || !enable || (ch_mask == '0)) begin
              state <= IDLE;
            end else begin
              ale_q  <= 1'b1;
              ph_cnt <= PH_W'(SETTLE - 1);
              state  <= SELECT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural ADC0808-style converter model.
module tb_adc_scan_ctrl;
  localparam int N_CH   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   enable = 1'b0;
  logic                   single = 1'b0;
  logic                   err_clr = 1'b0;
  logic [N_CH-1:0]        ch_mask = '0;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic                   sample_stb;
  logic [SEL_W-1:0]       sample_ch;
  logic                   scan_done;
  logic                   busy;
  logic                   err_timeout;

  adc_scan_ctrl_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) adc ();

  adc_scan_ctrl #(
    .N_CH(N_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .CLK_DIV(79),
    .SETTLE(4), .START_W(4), .OE_W(3), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .single(single),
    .ch_mask(ch_mask), .err_clr(err_clr), .adc(adc),
    .ch_data(ch_data), .sample_stb(sample_stb), .sample_ch(sample_ch),
    .scan_done(scan_done), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Converter model: result = data_base + latched channel; EOC low 3 cycles after
  // START falls, high 10 cycles later unless the channel is marked hung.
  logic [7:0]       data_base = 8'h00;
  logic [SEL_W-1:0] ch_lat = '0;
  logic             hang_en = 1'b0;
  logic [SEL_W-1:0] hang_ch = '0;

  assign adc.adc_data = data_base + 8'(ch_lat);

  always @(negedge adc.adc_ale) ch_lat = adc.adc_sel;

  initial begin
    adc.adc_eoc = 1'b1;
    forever begin
      @(negedge adc.adc_start);
      repeat (3) @(posedge clk);
      @(negedge clk);
      adc.adc_eoc = 1'b0;
      if (hang_en && (ch_lat == hang_ch)) wait (!hang_en);
      else repeat (10) @(posedge clk);
      @(negedge clk);
      adc.adc_eoc = 1'b1;
    end
  end

  // Monitor: records samples, ALE addresses and scan_done pulses.
  logic [3:0]       samp_q[$];
  logic [3:0]       ale_q[$];
  int               done_cnt = 0;
  logic [3:0]       exp_done_ch = '0;
  logic             stop_on_done = 1'b0;
  logic             ale_prev = 1'b0;
  logic             pend_chk = 1'b0;
  logic [3:0]       pend_ch = '0;
  logic [7:0]       pend_val = '0;

  always @(negedge clk) begin
    if (pend_chk) begin
      check("ch_data_after_stb", 64'(ch_data[int'(pend_ch)*DATA_W +: DATA_W]), 64'(pend_val));
      pend_chk = 1'b0;
    end
    if (sample_stb) begin
      check("stb_with_oe", 64'(adc.adc_oe), 64'd1);
      samp_q.push_back(4'(sample_ch));
      pend_chk = 1'b1;
      pend_ch  = 4'(sample_ch);
      pend_val = data_base + 8'(sample_ch);
    end
    if (scan_done) begin
      done_cnt++;
      if (samp_q.size() > 0) check("done_after_ch", 64'(samp_q[$]), 64'(exp_done_ch));
      if (stop_on_done) enable = 1'b0;
    end
    if (adc.adc_ale && !ale_prev) ale_q.push_back(4'(adc.adc_sel));
    ale_prev = adc.adc_ale;
  end

  task automatic check_seq(input string nm, input logic [3:0] q[$], input logic [31:0] seq, input int n);
    check({nm, "_count"}, 64'(q.size()), 64'(n));
    for (int k = 0; k < n && k < q.size(); k++)
      check($sformatf("%s_%0d", nm, k), 64'(q[k]), 64'(seq[4*k +: 4]));
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  base;
    logic        hang;
    logic [2:0]  hang_ch;
    int          n;
    logic [31:0] seq;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic clear_mon();
    samp_q.delete();
    ale_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    bit ok;
    int k;

    vecs[0] = '{8'hFF, 8'h10, 1'b0, 3'd0, 8, 32'h76543210, 64'h17161514_13121110, 1'b0};
    vecs[1] = '{8'h01, 8'h20, 1'b0, 3'd0, 1, 32'h00000000, 64'h17161514_13121120, 1'b0};
    vecs[2] = '{8'h80, 8'h30, 1'b0, 3'd0, 1, 32'h00000007, 64'h37161514_13121120, 1'b0};
    vecs[3] = '{8'h52, 8'h40, 1'b0, 3'd0, 3, 32'h00000641, 64'h37461544_13124120, 1'b0};
    vecs[4] = '{8'h0F, 8'h50, 1'b1, 3'd3, 3, 32'h00000210, 64'h37461544_13525150, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pins", 64'({adc.adc_clk, adc.adc_ale, adc.adc_start, adc.adc_oe, adc.adc_sel}), 64'd0);
    check("rst_status", 64'({sample_stb, sample_ch, scan_done, busy, err_timeout}), 64'd0);
    check("rst_ch_data", ch_data, 64'd0);

    // Divider: first rise 79 cycles after release, then 79 high / 79 low
    reset = 1'b1;
    k = 0; ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1; k++;
      if (adc.adc_clk) begin ok = 1; break; end
    end
    check("div_first_rise", 64'(k), 64'd79);
    k = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1; k++;
      if (!adc.adc_clk) break;
    end
    check("div_high", 64'(k), 64'd79);
    k = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1; k++;
      if (adc.adc_clk) break;
    end
    check("div_low", 64'(k), 64'd79);
    @(negedge clk);

    // Single-scan vectors
    for (int t = 0; t < 5; t++) begin
      clear_mon();
      data_base    = vecs[t].base;
      hang_en      = vecs[t].hang;
      hang_ch      = vecs[t].hang_ch;
      exp_done_ch  = 4'(vecs[t].seq[4*(vecs[t].n-1) +: 4]);
      stop_on_done = 1'b1;
      single       = 1'b1;
      ch_mask      = vecs[t].mask;
      check($sformatf("v%0d_err_before", t), 64'(err_timeout), 64'd0);
      enable       = 1'b1;
      ok = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (done_cnt > 0 && !busy) begin ok = 1; break; end
      end
      check($sformatf("v%0d_finished", t), 64'(ok), 64'd1);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check_seq($sformatf("v%0d_samp", t), samp_q, vecs[t].seq, vecs[t].n);
      check($sformatf("v%0d_done_cnt", t), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_busy", t), 64'(busy), 64'd0);
      check($sformatf("v%0d_ch_data", t), ch_data, vecs[t].exp_data);
      check($sformatf("v%0d_err", t), 64'(err_timeout), 64'(vecs[t].exp_err));
      hang_en = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check($sformatf("v%0d_err_clr", t), 64'(err_timeout), 64'd0);
      repeat (20) @(negedge clk);
    end
    stop_on_done = 1'b0;

    // Stop: enable dropped during WAIT_HI of channel 1
    clear_mon();
    data_base = 8'h70; single = 1'b0; ch_mask = 8'h0F; exp_done_ch = 4'd3;
    enable = 1'b1;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (ch_lat == 3'd1 && !adc.adc_eoc) begin ok = 1; break; end
    end
    check("stop_reach_ch1", 64'(ok), 64'd1);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("stop_idle", 64'(ok), 64'd1);
    repeat (10) @(negedge clk);
    check_seq("stop_samp", samp_q, 32'h10, 2);
    check_seq("stop_ale", ale_q, 32'h10, 2);
    check("stop_done_cnt", 64'(done_cnt), 64'd0);
    check("stop_ch_data", 64'(ch_data[15:0]), 64'h7170);

    // Sparse continuous scan from a cleared register file
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_mon();
    data_base = 8'h60; single = 1'b0; ch_mask = 8'b1010_0100; exp_done_ch = 4'd7;
    enable = 1'b1;
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (samp_q.size() >= 6) begin ok = 1; break; end
    end
    enable = 1'b0;
    check("sparse_six_samples", 64'(ok), 64'd1);
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("sparse_idle", 64'(ok), 64'd1);
    check_seq("sparse_samp", samp_q, 32'h00752752, 6);
    check_seq("sparse_ale", ale_q, 32'h00752752, 6);
    check("sparse_done_cnt", 64'(done_cnt), 64'd2);
    check("sparse_ch_data", ch_data, 64'h67006500_00620000);

    // Reset while OE is high
    clear_mon();
    data_base = 8'h80; single = 1'b0; ch_mask = 8'h06;
    enable = 1'b1;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (adc.adc_oe) begin ok = 1; break; end
    end
    check("rst_reach_oe", 64'(ok), 64'd1);
    reset = 1'b0;
    pend_chk = 1'b0;
    #1;
    check("midrst_pins", 64'({adc.adc_clk, adc.adc_ale, adc.adc_start, adc.adc_oe, adc.adc_sel}), 64'd0);
    check("midrst_status", 64'({sample_stb, sample_ch, scan_done, busy, err_timeout}), 64'd0);
    check("midrst_ch_data", ch_data, 64'd0);
    repeat (2) @(negedge clk);
    ale_q.delete();
    reset = 1'b1;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ale_q.size() > 0) begin ok = 1; break; end
    end
    check("restart_ale_seen", 64'(ok), 64'd1);
    if (ale_q.size() > 0) check("restart_first_ch", 64'(ale_q[0]), 64'd1);
    enable = 1'b0;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("final_idle", 64'(ok), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
